// File: rtl/cnn_div_seq_24s_14s_pkg.sv
// Shared definitions for the sequential signed divider (24s / 14s).
//   state_t  : divider FSM states
//   dbg_t    : debug view of the FSM state and the step counter
//   DIVIDEND_W_DEF / DIVISOR_W_DEF : default operand widths
//   QMAX / QMIN : quotient saturation / wrap values
//   CNT_W    : step counter width
package cnn_div_pkg;

  localparam int DIVIDEND_W_DEF = 24;
  localparam int DIVISOR_W_DEF  = 14;
  localparam int CNT_W          = $clog2(DIVIDEND_W_DEF + 1);

  localparam logic [DIVIDEND_W_DEF-1:0] QMAX = 24'h7FFFFF;
  localparam logic [DIVIDEND_W_DEF-1:0] QMIN = 24'h800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] cnt;
  } dbg_t;

endpackage

// File: rtl/cnn_div_seq_24s_14s_if.sv
// Operand/result bus of the sequential signed divider.
//   in_vld/in_rdy   : operand pair (dividend, divisor) handshake
//   out_vld/out_rdy : result (quot, rem, div_zero, ovf) handshake
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holding valid keeps its
// payload stable until that edge; ready may be given or withheld freely.
// modport master : the side that supplies operands and consumes results
// modport slave  : the divider
interface cnn_div_seq_24s_14s_if #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 14
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DIVIDEND_W-1:0] quot;
  logic [DIVISOR_W-1:0]  rem;
  logic                  div_zero;
  logic                  ovf;

  modport master (
    output in_vld, dividend, divisor, out_rdy,
    input  in_rdy, out_vld, quot, rem, div_zero, ovf
  );

  modport slave (
    input  in_vld, dividend, divisor, out_rdy,
    output in_rdy, out_vld, quot, rem, div_zero, ovf
  );
endinterface

// File: rtl/cnn_div_seq_24s_14s_u_core.sv
// Unsigned iterative restoring divider core.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture a (magnitude of dividend) and b (magnitude of divisor)
//   step     : perform one restoring step, MSB of the dividend first
//   q, r     : quotient / remainder registers (final after N steps)
//   cnt      : number of steps performed since load
//   last     : the step now in progress is the final one
module cnn_div_u_core
  import cnn_div_pkg::*;
#(
  parameter int N  = DIVIDEND_W_DEF,
  parameter int M  = DIVISOR_W_DEF,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [N-1:0]  a,
  input  logic [M-1:0]  b,
  output logic [N-1:0]  q,
  output logic [M-1:0]  r,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [N-1:0]  q_r;
  logic [M-1:0]  r_r;
  logic [M-1:0]  b_r;
  logic [CW-1:0] cnt_r;

  // Partial remainder with the next dividend bit shifted in: M+1 bits, since
  // the held remainder is below b (< 2^(M-1)+1) and doubling it needs one more.
  logic [M:0] shifted;
  logic       fits;

  assign shifted = {r_r, q_r[N-1]};
  assign fits    = (shifted >= {1'b0, b_r});

  // The dividend register doubles as the quotient register: each step shifts
  // out one dividend bit at the top and shifts in one quotient bit at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= '0;
      r_r   <= '0;
      b_r   <= '0;
      cnt_r <= '0;
    end else if (load) begin
      q_r   <= a;
      r_r   <= '0;
      b_r   <= b;
      cnt_r <= '0;
    end else if (step) begin
      r_r   <= fits ? M'(shifted - {1'b0, b_r}) : shifted[M-1:0];
      q_r   <= {q_r[N-2:0], fits};
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign q    = q_r;
  assign r    = r_r;
  assign cnt  = cnt_r;
  assign last = (cnt_r == CW'(N - 1));

endmodule

// File: rtl/cnn_div_seq_24s_14s.sv
// Sequential signed divider: 24-bit signed dividend / 14-bit signed divisor
// -> 24-bit quotient (truncated toward zero) and 14-bit remainder (sign of
// the dividend). One division in flight; constant latency of 26 edges from
// operand acceptance to out_vld.
// Build option: define CNN_DIV_SAT_EN to saturate the quotient on divide by
// zero and on -2^23 / -1; otherwise those cases return raw/wrapped values.
// Ports:
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   s              : operand/result bus (slave side)
//   dbg            : FSM state and step counter for observation
module cnn_div_seq_24s_14s
  import cnn_div_pkg::*;
#(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int          DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  cnn_div_seq_24s_14s_if.slave   s,
  output dbg_t                   dbg
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  // Instance tag only; it has no functional effect.
  logic unused_id;
  assign unused_id = ^ID;

  state_t state, state_nxt;
  logic   load, step, fix;

  logic [DIVIDEND_W-1:0] a_abs;
  logic [DIVISOR_W-1:0]  b_abs;
  logic [DIVIDEND_W-1:0] core_q;
  logic [DIVISOR_W-1:0]  core_r;
  logic [CW-1:0]         core_cnt;
  logic                  core_last;

  logic sign_a, sign_b, zero_lat, ovf_lat;
`ifndef CNN_DIV_SAT_EN
  logic [DIVISOR_W-1:0] rem_raw;
`endif

  logic [DIVIDEND_W-1:0] quot_q, quot_fix;
  logic [DIVISOR_W-1:0]  rem_q, rem_fix;
  logic                  div_zero_q, ovf_q, out_vld_q;

  // Magnitudes as unsigned values: -2^23 maps to 2^23, which fits 24 bits.
  assign a_abs = s.dividend[DIVIDEND_W-1] ? -s.dividend : s.dividend;
  assign b_abs = s.divisor[DIVISOR_W-1]   ? -s.divisor  : s.divisor;

  cnn_div_u_core #(
    .N (DIVIDEND_W),
    .M (DIVISOR_W),
    .CW(CW)
  ) u_core (
    .clk (ap_clk),
    .rst (ap_rst),
    .load(load),
    .step(step),
    .a   (a_abs),
    .b   (b_abs),
    .q   (core_q),
    .r   (core_r),
    .cnt (core_cnt),
    .last(core_last)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        if (s.in_vld) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (core_last) state_nxt = FIX;
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_vld_q && s.out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign application and special-case override of the unsigned result.
  always_comb begin
    quot_fix = (sign_a ^ sign_b) ? -core_q : core_q;
    rem_fix  = sign_a ? -core_r : core_r;
`ifdef CNN_DIV_SAT_EN
    if (zero_lat) begin
      quot_fix = sign_a ? DIVIDEND_W'(QMIN) : DIVIDEND_W'(QMAX);
      rem_fix  = '0;
    end else if (ovf_lat) begin
      quot_fix = DIVIDEND_W'(QMAX);
      rem_fix  = '0;
    end
`else
    if (zero_lat) begin
      quot_fix = '0;
      rem_fix  = rem_raw;
    end else if (ovf_lat) begin
      quot_fix = DIVIDEND_W'(QMIN);
      rem_fix  = '0;
    end
`endif
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      zero_lat   <= 1'b0;
      ovf_lat    <= 1'b0;
`ifndef CNN_DIV_SAT_EN
      rem_raw    <= '0;
`endif
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (load) begin
      sign_a     <= s.dividend[DIVIDEND_W-1];
      sign_b     <= s.divisor[DIVISOR_W-1];
      zero_lat   <= (s.divisor == '0);
      ovf_lat    <= (s.dividend == DIVIDEND_W'(QMIN)) && (s.divisor == '1);
`ifndef CNN_DIV_SAT_EN
      rem_raw    <= s.dividend[DIVISOR_W-1:0];
`endif
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (fix) begin
      quot_q     <= quot_fix;
      rem_q      <= rem_fix;
      div_zero_q <= zero_lat;
      ovf_q      <= ovf_lat;
    end
  end

  // out_vld is registered, so it rises on the edge after DONE is entered;
  // that extra edge is part of the fixed 26-edge latency. It drops on the
  // same edge that completes the result handshake.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) out_vld_q <= 1'b0;
    else        out_vld_q <= (state == DONE) && !(out_vld_q && s.out_rdy);
  end

  assign s.in_rdy   = (state == IDLE);
  assign s.out_vld  = out_vld_q;
  assign s.quot     = quot_q;
  assign s.rem      = rem_q;
  assign s.div_zero = div_zero_q;
  assign s.ovf      = ovf_q;

  assign dbg.state = state;
  assign dbg.cnt   = CNT_W'(core_cnt);

endmodule

// File: tb/tb_cnn_div_seq_24s_14s.sv
// Self-checking bench for cnn_div_seq_24s_14s: directed and random operand
// pairs, latency, backpressure, dropped in_vld and asynchronous mid-run reset.
module tb_cnn_div_seq_24s_14s;
  import cnn_div_pkg::*;

  localparam int W = 40; // {quot[23:0], rem[13:0], div_zero, ovf}

  logic ap_clk;
  logic ap_rst;
  dbg_t dbg;

  cnn_div_seq_24s_14s_if #(.DIVIDEND_W(24), .DIVISOR_W(14)) bus ();

  cnn_div_seq_24s_14s #(
    .ID(32'd1), .DIVIDEND_W(24), .DIVISOR_W(14)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .s     (bus),
    .dbg   (dbg)
  );

  // ---------------- clock / reset ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model built on the language's signed division (truncating).
  function automatic logic [W-1:0] model(input logic signed [23:0] a, input logic signed [13:0] b);
    longint la, lb;
    logic [23:0] q;
    logic [13:0] r;
    logic dz, ov;
    la = a;
    lb = b;
    dz = (lb == 0);
    ov = (la == -64'sd8388608) && (lb == -64'sd1);
    if (dz) begin
`ifdef CNN_DIV_SAT_EN
      q = (la >= 0) ? 24'h7FFFFF : 24'h800000;
      r = 14'd0;
`else
      q = 24'd0;
      r = a[13:0];
`endif
    end else if (ov) begin
`ifdef CNN_DIV_SAT_EN
      q = 24'h7FFFFF;
`else
      q = 24'h800000;
`endif
      r = 14'd0;
    end else begin
      q = 24'(la / lb);
      r = 14'(la % lb);
    end
    return {q, r, dz, ov};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [23:0] a, input logic [13:0] b, input bit push);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!bus.in_rdy && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    check("in_rdy_before_send", bus.in_rdy, 1);
    if (!bus.in_rdy) return;
    bus.in_vld   = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge ap_clk);
    bus.in_vld = 1'b0;
  endtask

  // Counts rising edges from the current point until out_vld is seen.
  task automatic wait_vld(output int lat);
    lat = 0;
    while (!bus.out_vld && lat < 100) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
  endtask

  task automatic recv(input bit check_lat);
    int lat;
    logic [W-1:0] e;
    wait_vld(lat);
    check("out_vld_timeout", bus.out_vld, 1);
    if (!bus.out_vld) return;
    if (check_lat) check("latency", lat, 26);
    check("sb_pending", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("quot", bus.quot, e[39:16]);
    check("rem", bus.rem, e[15:2]);
    check("div_zero", bus.div_zero, e[1]);
    check("ovf", bus.ovf, e[0]);
    check("in_rdy_busy", bus.in_rdy, 0);
    @(negedge ap_clk);
    bus.out_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    check("out_vld_after_hs", bus.out_vld, 0);
    check("in_rdy_after_hs", bus.in_rdy, 1);
    @(negedge ap_clk);
    bus.out_rdy = 1'b0;
  endtask

  // ---------------- directed table ----------------
  localparam int ND = 14;
  logic [23:0] dir_a [ND] = '{24'd100, -24'sd100, 24'd100, 24'h800000, 24'd5, -24'sd5,
                              -24'sd1, 24'h7FFFFF, 24'h800000, 24'h800000, 24'd0,
                              -24'sd7, -24'sd100, 24'd8191};
  logic [13:0] dir_b [ND] = '{14'd7, 14'd7, -14'sd7, 14'h3FFF, 14'd0, 14'd0,
                              14'd5, 14'h2000, 14'h2000, 14'd1, 14'd3,
                              -14'sd7, -14'sd7, 14'h1FFF};

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] e;
    int lat;
    bit found;

    ap_rst       = 1'b1;
    bus.in_vld   = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.out_rdy  = 1'b0;

    repeat (3) @(negedge ap_clk);
    check("rst_in_rdy", bus.in_rdy, 1);
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_quot", bus.quot, 0);
    check("rst_rem", bus.rem, 0);
    check("rst_flags", {bus.div_zero, bus.ovf}, 0);
    check("rst_state", dbg.state, IDLE);
    check("rst_cnt", dbg.cnt, 0);
    ap_rst = 1'b0;

    // directed cases, each with latency measurement
    for (int i = 0; i < ND; i++) begin
      send(dir_a[i], dir_b[i], 1);
      recv(1);
    end

    // random cases
    for (int i = 0; i < 24; i++) begin
      logic [23:0] ra;
      logic [13:0] rb;
      ra = 24'($urandom_range(0, 24'hFFFFFF));
      rb = 14'($urandom_range(0, 14'h3FFF));
      if (i % 8 == 3) rb = 14'd0;
      if (i % 8 == 5) rb = 14'h3FFF;
      send(ra, rb, 1);
      recv(1);
    end

    // backpressure: result held, in_vld pulses dropped
    send(24'd1000, -14'sd3, 1);
    wait_vld(lat);
    check("bp_latency", lat, 26);
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      bus.in_vld   = (i % 2 == 0);
      bus.dividend = 24'($urandom_range(0, 24'hFFFFFF));
      bus.divisor  = 14'($urandom_range(1, 14'h3FFF));
      @(posedge ap_clk);
      #1;
      check("bp_out_vld", bus.out_vld, 1);
      check("bp_in_rdy", bus.in_rdy, 0);
      check("bp_quot", bus.quot, e[39:16]);
      check("bp_rem", bus.rem, e[15:2]);
    end
    @(negedge ap_clk);
    bus.in_vld = 1'b0;
    recv(0);
    repeat (40) @(negedge ap_clk);
    check("bp_no_ghost_result", bus.out_vld, 0);
    check("bp_sb_empty", exp_q.size(), 0);

    // asynchronous reset at CALC step 10: in-flight division discarded
    send(24'd123456, 14'd77, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge ap_clk);
      if (dbg.state == CALC && dbg.cnt == 10) found = 1'b1;
    end
    check("rst_reach_step10", found, 1);
    #2;
    ap_rst = 1'b1;
    #1;
    check("midrst_out_vld", bus.out_vld, 0);
    check("midrst_in_rdy", bus.in_rdy, 1);
    check("midrst_state", dbg.state, IDLE);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (30) @(negedge ap_clk);
    check("midrst_no_result", bus.out_vld, 0);
    send(24'd9, 14'd3, 1);
    recv(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
